z80_bus_responder: RTL and testbench



---
 rtl/z80_bus_responder_pkg.sv | 27 ++
 rtl/z80_bus_responder_if.sv | 31 +++
 rtl/z80_bus_responder_intc.sv | 69 ++++++
 rtl/z80_bus_responder.sv | 181 ++++++++++++++++++
 tb/tb_z80_bus_responder.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/z80_bus_responder_pkg.sv
// Shared constants and payload types for the Z80 bus responder and its interrupt controller.
package z80_bus_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_MEM   = 2'd1;
    localparam logic [STATE_W-1:0] ST_HOLD  = 2'd2;
    localparam logic [STATE_W-1:0] ST_DRAIN = 2'd3;

    localparam logic [7:0] IO_VEC  = 8'd0;
    localparam logic [7:0] IO_STAT = 8'd1;

    localparam int unsigned STAT_EN   = 0;
    localparam int unsigned STAT_PEND = 1;
    localparam int unsigned STAT_TMO  = 2;

    localparam logic [7:0] BUS_IDLE = 8'hFF;

    // Backend request payload latched at the start of a memory access.
    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } mem_cmd_t;

endpackage

// File: rtl/z80_bus_responder_if.sv
// CPU pin bundle plus backend handshake; slave = responder, master = CPU/backend side.
interface z80_bus_responder_if;
    logic [15:0] A;
    logic [7:0]  dout;
    logic        m1_n;
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        rfsh_n;
    logic [7:0]  di;
    logic        wait_n;
    logic        int_n;
    logic        irq;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    modport slave (
        input  A, dout, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, irq, mem_ack, mem_rdata,
        output di, wait_n, int_n, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output A, dout, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, irq, mem_ack, mem_rdata,
        input  di, wait_n, int_n, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/z80_bus_responder_intc.sv
// Interrupt controller: vector/enable/pending/timeout registers, irq edge detect, registered int_n.
module z80_resp_intc
    import z80_bus_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       irq,
    input  logic       vec_we,
    input  logic       ctl_we,
    input  logic [7:0] wdata,
    input  logic       inta_ack,
    input  logic       tmo_set,
    output logic [7:0] vec,
    output logic [7:0] status,
    output logic       int_n
);

    logic [7:0] vec_q;
    logic       enable_q;
    logic       pending_q;
    logic       timeout_q;
    logic       irq_q;
    logic       int_n_q;
    logic       irq_rise_c;

    assign irq_rise_c = irq && !irq_q;

    // A new edge beats a same-cycle software or INTA clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vec_q     <= BUS_IDLE;
            enable_q  <= 1'b0;
            pending_q <= 1'b0;
            timeout_q <= 1'b0;
            irq_q     <= 1'b0;
            int_n_q   <= 1'b1;
        end else begin
            irq_q   <= irq;
            int_n_q <= !(pending_q && enable_q);
            if (vec_we) begin
                vec_q <= wdata;
            end
            if (ctl_we) begin
                enable_q <= wdata[STAT_EN];
            end
            if (irq_rise_c) begin
                pending_q <= 1'b1;
            end else if (inta_ack || (ctl_we && wdata[STAT_PEND])) begin
                pending_q <= 1'b0;
            end
            if (tmo_set) begin
                timeout_q <= 1'b1;
            end else if (ctl_we && wdata[STAT_TMO]) begin
                timeout_q <= 1'b0;
            end
        end
    end

    always_comb begin
        status            = '0;
        status[STAT_EN]   = enable_q;
        status[STAT_PEND] = pending_q;
        status[STAT_TMO]  = timeout_q;
    end

    assign vec   = vec_q;
    assign int_n = int_n_q;

endmodule

// File: rtl/z80_bus_responder.sv
// Z80 bus target: forwards memory cycles to a req/ack backend, stretches the CPU with wait_n,
// serves two I/O registers and the IM2 vector. Optional ack timeout: Z80_RESP_TIMEOUT_EN.
module z80_bus_responder
    import z80_bus_pkg::*;
#(
    parameter int unsigned MIN_WAIT = 0,
    parameter logic [7:0]  IO_BASE  = 8'h80,
    parameter int unsigned TIMEOUT  = 255
) (
    input logic           clk,
    input logic           reset,
    z80_bus_responder_if.slave bus
);

    localparam int unsigned        WCNT_W   = 4;
    localparam logic [WCNT_W-1:0]  WCNT_MAX = '1;
    localparam logic [WCNT_W-1:0]  WCNT_MIN = WCNT_W'(MIN_WAIT);

    logic [STATE_W-1:0] state, state_d;
    mem_cmd_t           cmd_q, cmd_d;
    logic               mem_req_q, mem_req_d;
    logic [7:0]         di_q, di_d;
    logic               ack_seen_q, ack_seen_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;

    logic       mem_acc_c, io_acc_c, inta_c;
    logic       ack_now_c, ack_done_c, wait_ok_c, tmo_hit_c;
    logic       is_vec_c, is_stat_c;
    logic       vec_we_c, ctl_we_c, inta_ack_c, tmo_set_c;
    logic [7:0] vec, status;
    logic       int_n;

    assign mem_acc_c = !bus.mreq_n && bus.rfsh_n && (!bus.rd_n || !bus.wr_n);
    assign io_acc_c  = !bus.iorq_n && bus.m1_n && (!bus.rd_n || !bus.wr_n);
    assign inta_c    = !bus.iorq_n && !bus.m1_n;

    assign is_vec_c  = (bus.A[7:0] == 8'(IO_BASE + IO_VEC));
    assign is_stat_c = (bus.A[7:0] == 8'(IO_BASE + IO_STAT));

    // An ack only counts against an outstanding request.
    assign ack_now_c  = bus.mem_ack && mem_req_q;
    assign ack_done_c = ack_seen_q || ack_now_c;
    assign wait_ok_c  = (wcnt_q >= WCNT_MIN);

`ifdef Z80_RESP_TIMEOUT_EN
    localparam int unsigned TMO_W = 16;
    logic [TMO_W-1:0] tcnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= (state == ST_MEM) ? tcnt_q + TMO_W'(1) : '0;
        end
    end

    assign tmo_hit_c = (state == ST_MEM) && !ack_done_c && (tcnt_q == TMO_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign tmo_hit_c      = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cmd_q      <= '0;
            mem_req_q  <= 1'b0;
            di_q       <= BUS_IDLE;
            ack_seen_q <= 1'b0;
            wcnt_q     <= '0;
        end else begin
            state      <= state_d;
            cmd_q      <= cmd_d;
            mem_req_q  <= mem_req_d;
            di_q       <= di_d;
            ack_seen_q <= ack_seen_d;
            wcnt_q     <= wcnt_d;
        end
    end

    always_comb begin
        state_d    = state;
        cmd_d      = cmd_q;
        mem_req_d  = mem_req_q;
        di_d       = di_q;
        ack_seen_d = ack_seen_q;
        wcnt_d     = wcnt_q;
        vec_we_c   = 1'b0;
        ctl_we_c   = 1'b0;
        inta_ack_c = 1'b0;
        tmo_set_c  = 1'b0;

        // mem_req only ever drops on an ack, whatever state we are in.
        if (ack_now_c) begin
            mem_req_d = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                if (inta_c) begin
                    di_d       = vec;
                    inta_ack_c = 1'b1;
                    state_d    = ST_HOLD;
                end else if (io_acc_c) begin
                    if (!bus.rd_n) begin
                        di_d = is_vec_c ? vec : (is_stat_c ? status : BUS_IDLE);
                    end else begin
                        vec_we_c = is_vec_c;
                        ctl_we_c = is_stat_c;
                    end
                    state_d = ST_HOLD;
                end else if (mem_acc_c) begin
                    cmd_d.addr  = bus.A;
                    cmd_d.wdata = bus.dout;
                    cmd_d.we    = !bus.wr_n;
                    mem_req_d   = 1'b1;
                    ack_seen_d  = 1'b0;
                    wcnt_d      = '0;
                    state_d     = ST_MEM;
                end
            end
            ST_MEM: begin
                if (wcnt_q != WCNT_MAX) begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
                if (ack_now_c) begin
                    ack_seen_d = 1'b1;
                    di_d       = bus.mem_rdata;
                end
                if (ack_done_c && wait_ok_c) begin
                    state_d = ST_HOLD;
                end else if (!mem_acc_c) begin
                    state_d = ack_done_c ? ST_IDLE : ST_DRAIN;
                end else if (tmo_hit_c) begin
                    di_d      = BUS_IDLE;
                    tmo_set_c = 1'b1;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // A timed-out request is still outstanding and must be drained.
                if (bus.mreq_n && bus.iorq_n) begin
                    state_d = mem_req_d ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!mem_req_d) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    z80_resp_intc u_intc (
        .clk      (clk),
        .reset    (reset),
        .irq      (bus.irq),
        .vec_we   (vec_we_c),
        .ctl_we   (ctl_we_c),
        .wdata    (bus.dout),
        .inta_ack (inta_ack_c),
        .tmo_set  (tmo_set_c),
        .vec      (vec),
        .status   (status),
        .int_n    (int_n)
    );

    // Combinational so a fresh access can stall the CPU before its T2 sample.
    assign bus.wait_n    = reset || !((mem_acc_c || io_acc_c || inta_c) && (state != ST_HOLD));
    assign bus.di        = (state == ST_HOLD) ? di_q : BUS_IDLE;
    assign bus.int_n     = int_n;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = cmd_q.we;
    assign bus.mem_addr  = cmd_q.addr;
    assign bus.mem_wdata = cmd_q.wdata;

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench for z80_bus_responder: two instances (MIN_WAIT 0 and 4) share one CPU/backend.
module tb_z80_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] a;
    logic [7:0]  dout;
    logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
    logic        irq, mem_ack;
    logic [7:0]  mem_rdata;
    int          vectors = 0;
    int          miscompares = 0;
    int          n;

    always #5 clk = ~clk;

    z80_bus_responder_if bus0 ();
    z80_bus_responder_if bus4 ();

    assign bus0.A = a;            assign bus4.A = a;
    assign bus0.dout = dout;      assign bus4.dout = dout;
    assign bus0.m1_n = m1_n;      assign bus4.m1_n = m1_n;
    assign bus0.mreq_n = mreq_n;  assign bus4.mreq_n = mreq_n;
    assign bus0.iorq_n = iorq_n;  assign bus4.iorq_n = iorq_n;
    assign bus0.rd_n = rd_n;      assign bus4.rd_n = rd_n;
    assign bus0.wr_n = wr_n;      assign bus4.wr_n = wr_n;
    assign bus0.rfsh_n = rfsh_n;  assign bus4.rfsh_n = rfsh_n;
    assign bus0.irq = irq;        assign bus4.irq = irq;
    assign bus0.mem_ack = mem_ack;      assign bus4.mem_ack = mem_ack;
    assign bus0.mem_rdata = mem_rdata;  assign bus4.mem_rdata = mem_rdata;

    z80_bus_responder #(.MIN_WAIT(0), .IO_BASE(8'h80), .TIMEOUT(16)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    z80_bus_responder #(.MIN_WAIT(4), .IO_BASE(8'h80), .TIMEOUT(16)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4)
    );

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic io_cycle(input string tag, input logic [7:0] port, input logic wr,
                            input logic [7:0] data, input logic [7:0] exp_di);
        tick;
        a = {8'h00, port};
        dout = data;
        iorq_n = 1'b0;
        if (wr) wr_n = 1'b0;
        else    rd_n = 1'b0;
        smp;
        check1({tag, " io wait"}, bus0.wait_n, 1'b0);
        tick;
        smp;
        check1({tag, " io release"}, bus0.wait_n, 1'b1);
        if (!wr) check8({tag, " io di"}, bus0.di, exp_di);
        tick;
        iorq_n = 1'b1;
        rd_n = 1'b1;
        wr_n = 1'b1;
    endtask

    task automatic mem_read(input string tag, input logic [15:0] addr, input int lat,
                            input logic [7:0] rd);
        tick;
        a = addr;
        mreq_n = 1'b0;
        rd_n = 1'b0;
        smp;
        check1({tag, " wait first"}, bus0.wait_n, 1'b0);
        check1({tag, " req first"}, bus0.mem_req, 1'b0);
        tick;
        smp;
        check1({tag, " req"}, bus0.mem_req, 1'b1);
        check16({tag, " addr"}, bus0.mem_addr, addr);
        check1({tag, " we"}, bus0.mem_we, 1'b0);
        check1({tag, " wait req"}, bus0.wait_n, 1'b0);
        for (int i = 0; i < lat; i++) begin
            tick;
            smp;
            check1({tag, " wait pend"}, bus0.wait_n, 1'b0);
        end
        mem_ack = 1'b1;
        mem_rdata = rd;
        tick;
        mem_ack = 1'b0;
        smp;
        check1({tag, " wait done"}, bus0.wait_n, 1'b1);
        check8({tag, " di"}, bus0.di, rd);
        check1({tag, " req drop"}, bus0.mem_req, 1'b0);
        repeat (6) tick;
        mreq_n = 1'b1;
        rd_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        a = '0; dout = '0; mem_rdata = '0;
        m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
        irq = 1'b0; mem_ack = 1'b0;

        // Reset values
        smp;
        check8("rst di", bus0.di, 8'hFF);
        check1("rst wait_n", bus0.wait_n, 1'b1);
        check1("rst int_n", bus0.int_n, 1'b1);
        check1("rst mem_req", bus0.mem_req, 1'b0);
        check1("rst mem_we", bus0.mem_we, 1'b0);
        check16("rst mem_addr", bus0.mem_addr, 16'h0000);
        check8("rst mem_wdata", bus0.mem_wdata, 8'h00);
        tick;
        reset = 1'b0;
        io_cycle("rst vec", 8'h80, 1'b0, 8'h00, 8'hFF);
        io_cycle("rst stat", 8'h81, 1'b0, 8'h00, 8'h00);

        // Memory reads: ack three cycles after req, then immediate ack
        mem_read("rd lat3", 16'h1234, 3, 8'h3C);
        mem_read("rd lat0", 16'h4567, 0, 8'h5A);

        // T2 write into the MIN_WAIT=4 instance with an immediate ack
        tick;
        a = 16'h8000; dout = 8'hA5; mreq_n = 1'b0;
        smp;
        check1("wr t1 wait", bus4.wait_n, 1'b1);
        check1("wr t1 req", bus4.mem_req, 1'b0);
        tick;
        wr_n = 1'b0;
        smp;
        check1("wr detect wait", bus4.wait_n, 1'b0);
        tick;
        smp;
        check1("wr req", bus4.mem_req, 1'b1);
        check1("wr we", bus4.mem_we, 1'b1);
        check8("wr wdata", bus4.mem_wdata, 8'hA5);
        check16("wr addr", bus4.mem_addr, 16'h8000);
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        smp;
        check1("wr req drop", bus4.mem_req, 1'b0);
        check1("wr wait c3", bus4.wait_n, 1'b0);
        check1("wr fast inst done", bus0.wait_n, 1'b1);
        repeat (3) tick;
        smp;
        check1("wr wait c6", bus4.wait_n, 1'b0);
        tick;
        smp;
        check1("wr wait c7", bus4.wait_n, 1'b1);
        tick;
        mreq_n = 1'b1; wr_n = 1'b1;

        // Refresh is ignored even with rd_n low
        tick;
        a = 16'h0012; mreq_n = 1'b0; rfsh_n = 1'b0; rd_n = 1'b0;
        smp;
        check1("rfsh wait", bus0.wait_n, 1'b1);
        tick;
        smp;
        check1("rfsh req", bus0.mem_req, 1'b0);
        check8("rfsh di", bus0.di, 8'hFF);
        tick;
        mreq_n = 1'b1; rfsh_n = 1'b1; rd_n = 1'b1;

`ifdef Z80_RESP_TIMEOUT_EN
        // Ack never arrives: timeout after 16 MEM cycles, then a late ack is swallowed
        tick;
        a = 16'h0200; mreq_n = 1'b0; rd_n = 1'b0;
        n = 0;
        smp;
        while (bus0.wait_n !== 1'b1 && n < 40) begin
            tick;
            smp;
            n++;
        end
        check16("tmo cycles", 16'(n), 16'd17);
        check8("tmo di", bus0.di, 8'hFF);
        check1("tmo req held", bus0.mem_req, 1'b1);
        tick;
        mreq_n = 1'b1; rd_n = 1'b1;
        tick;
        mem_ack = 1'b1; mem_rdata = 8'h77;
        tick;
        mem_ack = 1'b0;
        smp;
        check1("tmo late ack", bus0.mem_req, 1'b0);
        io_cycle("tmo stat", 8'h81, 1'b0, 8'h00, 8'h04);
        io_cycle("tmo clr", 8'h81, 1'b1, 8'h04, 8'h00);
        io_cycle("tmo stat clr", 8'h81, 1'b0, 8'h00, 8'h00);
        mem_read("tmo next", 16'h0300, 0, 8'h66);
`endif

        // Interrupt controller: vector, enable, edge, INTA
        io_cycle("vec wr", 8'h80, 1'b1, 8'h42, 8'h00);
        io_cycle("en wr", 8'h81, 1'b1, 8'h01, 8'h00);
        io_cycle("en stat", 8'h81, 1'b0, 8'h00, 8'h01);
        tick;
        irq = 1'b1;
        tick;
        irq = 1'b0;
        tick;
        smp;
        check1("irq int_n", bus0.int_n, 1'b0);
        tick;
        m1_n = 1'b0; iorq_n = 1'b0;
        smp;
        check1("inta wait", bus0.wait_n, 1'b0);
        tick;
        smp;
        check1("inta release", bus0.wait_n, 1'b1);
        check8("inta vector", bus0.di, 8'h42);
        tick;
        m1_n = 1'b1; iorq_n = 1'b1;
        smp;
        check1("inta int_n", bus0.int_n, 1'b1);
        io_cycle("inta stat", 8'h81, 1'b0, 8'h00, 8'h01);

        // Software clear of pending
        tick;
        irq = 1'b1;
        tick;
        irq = 1'b0;
        tick;
        smp;
        check1("irq2 int_n", bus0.int_n, 1'b0);
        io_cycle("sw clr", 8'h81, 1'b1, 8'h03, 8'h00);
        io_cycle("sw clr stat", 8'h81, 1'b0, 8'h00, 8'h01);
        smp;
        check1("sw clr int_n", bus0.int_n, 1'b1);

        // Disabled: pending still records, int_n stays high
        io_cycle("dis wr", 8'h81, 1'b1, 8'h00, 8'h00);
        tick;
        irq = 1'b1;
        tick;
        irq = 1'b0;
        repeat (2) tick;
        smp;
        check1("dis int_n", bus0.int_n, 1'b1);
        io_cycle("dis stat", 8'h81, 1'b0, 8'h00, 8'h02);

        // Unmapped ports
        io_cycle("unmap rd", 8'h90, 1'b0, 8'h00, 8'hFF);
        io_cycle("unmap wr", 8'h90, 1'b1, 8'h13, 8'h00);
        io_cycle("unmap vec", 8'h80, 1'b0, 8'h00, 8'h42);

        // Asynchronous reset with a request outstanding
        tick;
        a = 16'h0400; mreq_n = 1'b0; rd_n = 1'b0;
        tick;
        smp;
        check1("arst req before", bus0.mem_req, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check1("arst req", bus0.mem_req, 1'b0);
        check1("arst wait_n", bus0.wait_n, 1'b1);
        check8("arst di", bus0.di, 8'hFF);
        check1("arst int_n", bus0.int_n, 1'b1);
        check16("arst addr", bus0.mem_addr, 16'h0000);
        mreq_n = 1'b1; rd_n = 1'b1;
        repeat (2) tick;
        reset = 1'b0;
        io_cycle("arst vec", 8'h80, 1'b0, 8'h00, 8'hFF);
        io_cycle("arst stat", 8'h81, 1'b0, 8'h00, 8'h00);

        repeat (2) tick;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
